// File: rtl/key_pwd_lock.sv
// 4-digit keypad password lock fed by the matrix key scanner's one-cycle key strobes.
// Define LOCKOUT_EN to add the MAX_FAIL lockout (LOCK state, T_LOCK timer, locked output).
module key_pwd_lock #(
  parameter logic [15:0] PWD      = 16'h1234,
  parameter int unsigned T_IDLE   = 125_000_000,
  parameter int unsigned T_OPEN   = 75_000_000,
  parameter int unsigned T_LOCK   = 250_000_000,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_num,
  input  logic        key_vld,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic        unlock,
  output logic        alarm,
  output logic        locked
);

  localparam int unsigned T_MAX = (T_IDLE > T_OPEN) ? ((T_IDLE > T_LOCK) ? T_IDLE : T_LOCK)
                                                    : ((T_OPEN > T_LOCK) ? T_OPEN : T_LOCK);
  localparam int TW = (T_MAX > 2) ? $clog2(T_MAX) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] IDLE_LAST = TW'(T_IDLE - 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(T_OPEN - 1);
`ifdef LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LAST = TW'(T_LOCK - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCK} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [15:0]     digits_d;
  logic [2:0]      cnt_d;
  logic            unlock_d, alarm_d;

  logic key_digit, key_enter, key_clear;
  assign key_digit = key_vld && (key_num <= 4'd9);
  assign key_enter = key_vld && (key_num == 4'hA);
  assign key_clear = key_vld && (key_num == 4'hB);

`ifdef LOCKOUT_EN
  logic locked_q, locked_d;
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    fail_d   = fail_q;
    digits_d = digits;
    cnt_d    = digit_cnt;
    unlock_d = unlock;
    alarm_d  = 1'b0;
`ifdef LOCKOUT_EN
    locked_d = locked_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (key_digit) begin
          state_d  = S_ENTRY;
          digits_d = {12'hFFF, key_num};
          cnt_d    = 3'd1;
        end
      end
      S_ENTRY: begin
        // A digit beyond the fourth is dropped and, like C..F, does not restart the timer.
        if (key_digit && digit_cnt < 3'd4) begin
          digits_d = {digits[11:0], key_num};
          cnt_d    = digit_cnt + 3'd1;
          timer_d  = '0;
        end else if (key_clear || (!key_enter && timer_q == IDLE_LAST)) begin
          state_d  = S_IDLE;
          digits_d = 16'hFFFF;
          cnt_d    = 3'd0;
        end else if (key_enter) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (digit_cnt == 3'd4 && digits == PWD) begin
          state_d  = S_OPEN;
          unlock_d = 1'b1;
          fail_d   = '0;
        end else begin
          alarm_d  = 1'b1;
          fail_d   = (fail_q == '1) ? fail_q : fail_q + 1'b1;
          digits_d = 16'hFFFF;
          cnt_d    = 3'd0;
          state_d  = S_IDLE;
`ifdef LOCKOUT_EN
          if (fail_q == FAIL_LAST) begin
            state_d  = S_LOCK;
            locked_d = 1'b1;
          end
`endif
        end
      end
      S_OPEN: begin
        if (key_clear || timer_q == OPEN_LAST) begin
          state_d  = S_IDLE;
          unlock_d = 1'b0;
          digits_d = 16'hFFFF;
          cnt_d    = 3'd0;
        end
      end
`ifdef LOCKOUT_EN
      S_LOCK: begin
        if (timer_q == LOCK_LAST) begin
          state_d  = S_IDLE;
          locked_d = 1'b0;
          fail_d   = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      fail_q    <= '0;
      digits    <= 16'hFFFF;
      digit_cnt <= 3'd0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      digits    <= digits_d;
      digit_cnt <= cnt_d;
      unlock    <= unlock_d;
      alarm     <= alarm_d;
    end
  end

`ifdef LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end
`endif

endmodule

// File: tb/tb_key_pwd_lock.sv
// Self-checking bench for key_pwd_lock: directed scenarios plus random key traffic,
// compared every cycle against a queue/countdown model of the lock's rules.
module tb_key_pwd_lock;

  localparam int T_IDLE   = 50;
  localparam int T_OPEN   = 20;
  localparam int T_LOCK   = 40;
  localparam int MAX_FAIL = 3;
  localparam logic [15:0] PWD = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_num = 4'd0;
  logic        key_vld = 1'b0;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        unlock, alarm, locked;

  int total = 0;
  int bad   = 0;

  key_pwd_lock #(
    .PWD(PWD), .T_IDLE(T_IDLE), .T_OPEN(T_OPEN), .T_LOCK(T_LOCK), .MAX_FAIL(MAX_FAIL)
  ) dut (
    .clk(clk), .rst(rst), .key_num(key_num), .key_vld(key_vld),
    .digits(digits), .digit_cnt(digit_cnt), .unlock(unlock), .alarm(alarm), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: entered digits as a queue, hold times as countdowns.
  int pwd_seq[4] = '{1, 2, 3, 4};
  int q[$];
  bit in_entry, check_pending, m_alarm;
  int quiet, open_left, lock_left, fails;

  function automatic bit entry_is_pwd();
    if (q.size() != 4) return 1'b0;
    foreach (pwd_seq[i]) if (q[i] != pwd_seq[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] exp_digits();
    logic [15:0] v = 16'hFFFF;
    foreach (q[i]) v = {v[11:0], 4'(q[i])};
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    in_entry = 0; check_pending = 0; m_alarm = 0;
    quiet = 0; open_left = 0; lock_left = 0; fails = 0;
  endtask

  // Advance the model across one rising edge with the given key inputs.
  task automatic model_step(input logic v, input logic [3:0] k);
    bit is_d, is_clr, is_ent;
    is_d   = v && (k <= 4'd9);
    is_clr = v && (k == 4'hB);
    is_ent = v && (k == 4'hA);
    m_alarm = 0;
    if (check_pending) begin
      check_pending = 0;
      if (entry_is_pwd()) begin
        open_left = T_OPEN;
        fails = 0;
      end else begin
        m_alarm = 1;
        if (fails < 3) fails++;
        q.delete();
`ifdef LOCKOUT_EN
        if (fails == MAX_FAIL) lock_left = T_LOCK;
`endif
      end
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (open_left > 0) begin
      if (is_clr) open_left = 0;
      else open_left--;
      if (open_left == 0) q.delete();
    end else if (in_entry) begin
      if (is_d && q.size() < 4) begin
        q.push_back(int'(k));
        quiet = 0;
      end else if (is_clr) begin
        in_entry = 0;
        q.delete();
      end else if (is_ent) begin
        in_entry = 0;
        check_pending = 1;
      end else if (quiet + 1 == T_IDLE) begin
        in_entry = 0;
        q.delete();
      end else begin
        quiet++;
      end
    end else if (is_d) begin
      in_entry = 1;
      q.delete();
      q.push_back(int'(k));
      quiet = 0;
    end
  endtask

  task automatic compare_all();
    check("digits", digits, exp_digits());
    check("digit_cnt", digit_cnt, q.size());
    check("unlock", unlock, open_left > 0);
    check("alarm", alarm, m_alarm);
    check("locked", locked, lock_left > 0);
  endtask

  task automatic tick(input logic v, input logic [3:0] k);
    @(negedge clk);
    compare_all();
    key_vld = v;
    key_num = k;
    model_step(v, k);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic press(input logic [3:0] k, input int gap);
    tick(1'b1, k);
    idle(gap);
  endtask

  task automatic enter_code(input logic [15:0] code, input int n);
    logic [15:0] c = code;
    for (int i = 0; i < n; i++) begin
      press(c[15:12], $urandom_range(0, 2));
      c = c << 4;
    end
    press(4'hA, 0);
  endtask

  // Reset asserted between edges: outputs must reach reset values before the next edge.
  task automatic async_reset();
    @(negedge clk);
    compare_all();
    key_vld = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_digits", digits, 16'hFFFF);
    check("rst_cnt", digit_cnt, 3'd0);
    check("rst_unlock", unlock, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_locked", locked, 1'b0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    model_step(1'b0, 4'd0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check("rst_digits", digits, 16'hFFFF);
    check("rst_cnt", digit_cnt, 3'd0);
    compare_all();
    rst = 1'b0;
    model_step(1'b0, 4'd0);
    idle(3);

    // Correct entry, full open window.
    enter_code(16'h1234, 4);
    idle(T_OPEN + 5);
    // Wrong entry.
    enter_code(16'h1235, 4);
    idle(5);
    // CLEAR mid-entry, then a fifth digit that must be dropped.
    press(4'd9, 1); press(4'd8, 1); press(4'hB, 2);
    press(4'd1, 0); press(4'd2, 0); press(4'd3, 0); press(4'd4, 0); press(4'd5, 1);
    press(4'hA, 0);
    idle(T_OPEN + 3);
    // Inactivity timeout without alarm.
    press(4'd7, 0);
    idle(T_IDLE + 5);
    // Three wrong entries, keys during any lockout, then a correct entry.
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h9999, 4);
      idle(2);
    end
    enter_code(16'h1234, 4);
    idle(T_LOCK + 5);
    enter_code(16'h1234, 4);
    idle(5);
    // CLEAR ends the open window early.
    press(4'hB, 3);
    // Keys C..F leave the entry untouched, then reset during entry and during OPEN.
    press(4'd1, 0); press(4'd2, 0);
    press(4'hC, 0); press(4'hD, 0); press(4'hE, 0); press(4'hF, 1);
    async_reset();
    idle(2);
    enter_code(16'h1234, 4);
    idle(5);
    async_reset();
    idle(2);

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      int r = $urandom_range(0, 11);
      if (r <= 3) begin
        enter_code(16'h1234, 4);
        idle($urandom_range(0, 25));
      end else if (r <= 6) begin
        logic [15:0] code = 16'($urandom);
        for (int d = 0; d < 4; d++) code[d*4 +: 4] = 4'($urandom_range(0, 9));
        enter_code(code, $urandom_range(0, 4));
        idle($urandom_range(0, 3));
      end else if (r == 7) begin
        press(4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end else if (r == 8) begin
        press(4'hB, $urandom_range(0, 2));
      end else if (r == 9) begin
        idle($urandom_range(T_IDLE, T_IDLE + 8));
      end else if (r == 10) begin
        for (int d = 0; d < $urandom_range(1, 5); d++)
          press(4'($urandom_range(0, 9)), $urandom_range(0, 2));
      end else begin
        if ($urandom_range(0, 3) == 0) async_reset();
        else idle($urandom_range(1, 4));
      end
    end
    idle(T_LOCK + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
